// File: rtl/wb_reg_file_pkg.sv
// Shared pipeline package: register-file geometry and the MEM/WB pipeline
// register layout used by the write-back stage.
package wb_reg_file_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [WORD_W-1:0]     word_t;

    // Fields carried by the MEM/WB pipeline register into write-back
    typedef struct packed {
        logic      wb_en;
        logic      mem_r_en;
        word_t     alu_res;
        word_t     mem_read_val;
        reg_addr_t dest;
    } mem_wb_t;

    // Value written back: memory read data for loads, ALU result otherwise
    function automatic word_t wb_select(input mem_wb_t f);
        return f.mem_r_en ? f.mem_read_val : f.alu_res;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32 x 32 register array with one write port and two combinational read
// ports. Register 0 is never written and always reads as zero.
module reg_file
    import wb_reg_file_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata,
    input  reg_addr_t raddr1,
    input  reg_addr_t raddr2,
    output word_t     rdata1,
    output word_t     rdata2
);

    word_t regs_q [REG_COUNT];
    word_t regs_d [REG_COUNT];

    // Next-state of the array: single write, index 0 excluded
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Array storage, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports, zero latency; index 0 forced to zero
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    end

endmodule

// File: rtl/wb_reg_file.sv
// Write-back stage plus register file: write-back mux, committed-write
// counter and optional same-cycle write-through to the read ports.
// Build option: define WB_REG_FILE_BYPASS_EN to return the pending
// write-back value on a read of the register being written.
module wb_reg_file
    import wb_reg_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_EN,
    input  logic                  MEM_R_EN,
    input  logic [WORD_W-1:0]     ALURes,
    input  logic [WORD_W-1:0]     memReadVal,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    output logic [WORD_W-1:0]     reg1,
    output logic [WORD_W-1:0]     reg2,
    output logic [WORD_W-1:0]     wbValue,
    output logic [WORD_W-1:0]     wbCount
);

    mem_wb_t mem_wb;
    logic    commit;
    word_t   rd1;
    word_t   rd2;
    word_t   wb_count_q;
    word_t   wb_count_d;

    // Write-back selection and commit qualifier; no reset dependence
    always_comb begin
        mem_wb  = '{wb_en: WB_EN, mem_r_en: MEM_R_EN, alu_res: ALURes,
                    mem_read_val: memReadVal, dest: dest};
        wbValue = wb_select(mem_wb);
        commit  = mem_wb.wb_en && (mem_wb.dest != '0);
    end

    reg_file u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (commit),
        .waddr  (dest),
        .wdata  (wbValue),
        .raddr1 (src1),
        .raddr2 (src2),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // Read outputs, with write-through of the pending value when enabled
    always_comb begin
`ifdef WB_REG_FILE_BYPASS_EN
        reg1 = (commit && (src1 == dest)) ? wbValue : rd1;
        reg2 = (commit && (src2 == dest)) ? wbValue : rd2;
`else
        reg1 = rd1;
        reg2 = rd2;
`endif
    end

    // Committed-write count, wraps naturally at 2^32
    always_comb begin
        wb_count_d = commit ? wb_count_q + 32'd1 : wb_count_q;
        wbCount    = wb_count_q;
    end

    // Counter storage, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count_q <= '0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file; expectations follow the
// WB_REG_FILE_BYPASS_EN setting of the build.
module tb_wb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic [31:0] ALURes;
    logic [31:0] memReadVal;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] wbValue;
    logic [31:0] wbCount;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .WB_EN      (WB_EN),
        .MEM_R_EN   (MEM_R_EN),
        .ALURes     (ALURes),
        .memReadVal (memReadVal),
        .dest       (dest),
        .src1       (src1),
        .src2       (src2),
        .reg1       (reg1),
        .reg2       (reg2),
        .wbValue    (wbValue),
        .wbCount    (wbCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a write at the falling edge, let it commit, then drop WB_EN
    task automatic do_write(input logic mre, input logic [31:0] alu,
                            input logic [31:0] mem, input logic [4:0] d);
        @(negedge clk);
        WB_EN      = 1'b1;
        MEM_R_EN   = mre;
        ALURes     = alu;
        memReadVal = mem;
        dest       = d;
        @(posedge clk);
        #1;
        WB_EN = 1'b0;
        #1;
    endtask

    logic [31:0] exp_byp;

    initial begin
        rst = 1'b0; WB_EN = 1'b0; MEM_R_EN = 1'b0;
        ALURes = 32'h0000_0055; memReadVal = 32'h0000_0066;
        dest = 5'd0; src1 = 5'd4; src2 = 5'd0;

        // Reset state and mux independence from reset
        #2;
        check("reset_reg1", reg1, 32'h0);
        check("reset_count", wbCount, 32'h0);
        check("reset_wbvalue_alu", wbValue, 32'h0000_0055);
        MEM_R_EN = 1'b1; #1;
        check("reset_wbvalue_mem", wbValue, 32'h0000_0066);

        // Write attempted while held in reset must not commit
        WB_EN = 1'b1; dest = 5'd4;
        @(posedge clk); #1;
        WB_EN = 1'b0; #1;
        check("reset_write_blocked", reg1, 32'h0);
        check("reset_write_count", wbCount, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Mux and write: ALU path then memory path
        @(negedge clk);
        WB_EN = 1'b1; MEM_R_EN = 1'b0; ALURes = 32'h0000_1234;
        memReadVal = 32'hDEAD_BEEF; dest = 5'd5; src1 = 5'd5; src2 = 5'd6;
        #1;
        check("mux_alu", wbValue, 32'h0000_1234);
        @(posedge clk); #1;
        WB_EN = 1'b0; #1;
        check("write_r5", reg1, 32'h0000_1234);
        check("count_1", wbCount, 32'd1);
        do_write(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd6);
        check("write_r6_mem", reg2, 32'hDEAD_BEEF);
        check("count_2", wbCount, 32'd2);

        // Same index on both read ports
        src1 = 5'd6; src2 = 5'd6; #1;
        check("same_src_reg1", reg1, 32'hDEAD_BEEF);
        check("same_src_reg2", reg2, 32'hDEAD_BEEF);

        // Register 0: write ignored, reads zero even with a pending write
        @(negedge clk);
        WB_EN = 1'b1; MEM_R_EN = 1'b0; ALURes = 32'hFFFF_FFFF; dest = 5'd0;
        src1 = 5'd0; #1;
        check("r0_pending", reg1, 32'h0);
        @(posedge clk); #1;
        WB_EN = 1'b0; #1;
        check("r0_after", reg1, 32'h0);
        check("r0_count", wbCount, 32'd2);

        // Bypass: seed r7, then a pending write to r7 seen before the edge
        do_write(1'b0, 32'h1111_0000, 32'h0, 5'd7);
        check("count_3", wbCount, 32'd3);
        @(negedge clk);
        WB_EN = 1'b1; MEM_R_EN = 1'b0; ALURes = 32'hA5A5_A5A5;
        memReadVal = 32'h0; dest = 5'd7; src1 = 5'd5; src2 = 5'd7;
`ifdef WB_REG_FILE_BYPASS_EN
        exp_byp = 32'hA5A5_A5A5;
`else
        exp_byp = 32'h1111_0000;
`endif
        #1;
        check("bypass_pre_edge", reg2, exp_byp);
        check("bypass_other_port", reg1, 32'h0000_1234);
        @(posedge clk); #1;
        WB_EN = 1'b0; #1;
        check("bypass_post_edge", reg2, 32'hA5A5_A5A5);
        check("count_4", wbCount, 32'd4);

        // WB_EN = 0 with toggling data leaves r9 and the count alone
        do_write(1'b0, 32'h0000_0099, 32'h0, 5'd9);
        src1 = 5'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            WB_EN = 1'b0; dest = 5'd9; MEM_R_EN = i[0];
            ALURes = 32'h1000_0000 + i; memReadVal = ~(32'h1000_0000 + i);
            #1;
            check("idle_r9_pre", reg1, 32'h0000_0099);
        end
        @(posedge clk); #1;
        check("idle_r9", reg1, 32'h0000_0099);
        check("idle_count", wbCount, 32'd5);

        // Counter wrap from all-ones
        @(negedge clk);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        #1;
        check("wrap_preload", wbCount, 32'hFFFF_FFFF);
        do_write(1'b0, 32'h0000_0333, 32'h0, 5'd3);
        src2 = 5'd3; #1;
        check("wrap_count", wbCount, 32'h0);
        check("wrap_r3", reg2, 32'h0000_0333);

        // Asynchronous mid-run reset, observed before the next edge
        src1 = 5'd5;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_reg1", reg1, 32'h0);
        check("async_rst_reg2", reg2, 32'h0);
        check("async_rst_count", wbCount, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        do_write(1'b1, 32'h0, 32'h0000_0777, 5'd5);
        check("post_rst_write", reg1, 32'h0000_0777);
        check("post_rst_count", wbCount, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
